// File: rtl/game_tick_ctrl.sv
// Game-step tick generator with selectable speed, pre-tick clear strobe and legacy slow clock,
// plus per-button synchroniser, debouncer, press detector and per-interval press capture.
module game_tick_ctrl #(
  parameter int BASE_PERIOD    = 4194304,
  parameter int CNT_W          = 22,
  parameter int N_BTN          = 4,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter int DEB_CYCLES     = 65536,
  parameter int DEB_W          = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       speed,
  input  logic             pause,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             tick,
  output logic             clear_pulse,
  output logic             slow_clk,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] tick_btns
);

  // One extra bit so the period register can hold BASE_PERIOD itself.
  localparam int               PER_W    = CNT_W + 1;
  localparam logic [PER_W-1:0] BASE_P   = PER_W'(BASE_PERIOD);
  localparam logic [N_BTN-1:0] RELEASED = BTN_ACTIVE_LOW ? '1 : '0;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [PER_W-1:0] period_reg;
  logic [PER_W-1:0] period_sel;
  logic [PER_W-1:0] cnt_next_ext;
  logic             wrap;

  always_comb begin
    period_sel   = BASE_P >> speed;
    wrap         = ({1'b0, cnt_reg} == period_reg - PER_W'(1));
    cnt_next     = wrap ? '0 : cnt_reg + CNT_W'(1);
    cnt_next_ext = {1'b0, cnt_next};
  end

  // tick/clear_pulse are decoded one cycle ahead so they line up with the cnt value they name.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      period_reg  <= BASE_P;
      tick        <= 1'b0;
      clear_pulse <= 1'b0;
      slow_clk    <= 1'b0;
    end else begin
      if (pause) begin
        tick        <= 1'b0;
        clear_pulse <= 1'b0;
      end else begin
        cnt_reg     <= cnt_next;
        if (wrap) period_reg <= period_sel;
        tick        <= (cnt_next_ext == period_reg - PER_W'(1));
        clear_pulse <= (cnt_next_ext == period_reg - PER_W'(2));
      end
      if (tick) slow_clk <= ~slow_clk;
    end
  end

  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;
  logic [N_BTN-1:0] btn_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= RELEASED;
      sync2_reg <= RELEASED;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign btn_s = sync2_reg ^ RELEASED;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [DEB_W-1:0] dcnt_reg;
      logic             level_reg;
      logic             press_reg;

      // Any cycle of agreement restarts the count, so short glitches never reach the level.
      always_ff @(posedge clk) begin
        if (reset) begin
          dcnt_reg  <= '0;
          level_reg <= 1'b0;
          press_reg <= 1'b0;
        end else begin
          press_reg <= 1'b0;
          if (btn_s[gi] == level_reg) begin
            dcnt_reg <= '0;
          end else if (dcnt_reg == DEB_LAST) begin
            level_reg <= btn_s[gi];
            press_reg <= btn_s[gi];
            dcnt_reg  <= '0;
          end else begin
            dcnt_reg <= dcnt_reg + DEB_W'(1);
          end
        end
      end

      assign btn_level[gi] = level_reg;
      assign btn_press[gi] = press_reg;
    end
  endgenerate

  logic [N_BTN-1:0] pending_reg;

  // A press landing in the tick cycle goes straight into tick_btns rather than into pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
      tick_btns   <= '0;
    end else if (tick) begin
      tick_btns   <= pending_reg | btn_press;
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_reg | btn_press;
    end
  end

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Scoreboard bench for game_tick_ctrl: expected ticks and presses are queued with their
// cycle numbers as stimulus is scheduled, and popped when the DUT strobes them.
module tb_game_tick_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] speed;
  logic       pause;
  logic [3:0] btn_raw;
  logic       tick;
  logic       clear_pulse;
  logic       slow_clk;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] tick_btns;

  game_tick_ctrl #(
    .BASE_PERIOD   (64),
    .CNT_W         (6),
    .N_BTN         (4),
    .BTN_ACTIVE_LOW(1'b1),
    .DEB_CYCLES    (4),
    .DEB_W         (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .speed      (speed),
    .pause      (pause),
    .btn_raw    (btn_raw),
    .tick       (tick),
    .clear_pulse(clear_pulse),
    .slow_clk   (slow_clk),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .tick_btns  (tick_btns)
  );

  typedef struct {
    int         cyc;
    logic [3:0] m;
  } ev_t;

  ev_t tick_q[$];
  ev_t press_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  logic rst_edge;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= reset ? 0 : cyc + 1;
    rst_edge <= reset;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input logic [3:0] m);
    ev_t e;
    e.cyc = c;
    e.m   = m;
    tick_q.push_back(e);
  endtask

  task automatic push_press(input int c, input logic [3:0] m);
    ev_t e;
    e.cyc = c;
    e.m   = m;
    press_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    int k;
    k = 0;
    while (cyc != c && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (cyc != c) check_eq("wait_cycle", cyc, c);
  endtask

  // Monitor: samples just after the falling edge.
  logic       prev_tick;
  logic       prev_clear;
  logic       exp_slow;
  logic [3:0] exp_btns;
  ev_t        mon_t;
  ev_t        mon_p;

  always @(negedge clk) begin
    #1;
    if (rst_edge === 1'b1) begin
      prev_tick  = 1'b0;
      prev_clear = 1'b0;
      exp_slow   = 1'b0;
    end else begin
      if (prev_clear) check_eq("tick_after_clear", tick, 1);
      if (tick) begin
        check_eq("clear_before_tick", prev_clear, 1);
        if (tick_q.size() == 0) begin
          check_eq("unexpected_tick", cyc, -1);
        end else begin
          mon_t = tick_q.pop_front();
          check_eq("tick_cycle", cyc, mon_t.cyc);
          check_eq("slow_clk", slow_clk, exp_slow);
          exp_slow = ~exp_slow;
          exp_btns = mon_t.m;
        end
      end
      if (prev_tick) check_eq("tick_btns", tick_btns, exp_btns);
      if (btn_press != 4'b0000) begin
        if (press_q.size() == 0) begin
          check_eq("unexpected_press", cyc, -1);
        end else begin
          mon_p = press_q.pop_front();
          check_eq("press_cycle", cyc, mon_p.cyc);
          check_eq("press_mask", btn_press, mon_p.m);
        end
      end
      prev_tick  = tick;
      prev_clear = clear_pulse;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    speed   = 2'd0;
    pause   = 1'b0;
    btn_raw = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_tick", tick, 0);
    check_eq("rst_clear", clear_pulse, 0);
    check_eq("rst_slow", slow_clk, 0);
    check_eq("rst_level", btn_level, 0);
    check_eq("rst_tick_btns", tick_btns, 0);

    push_tick(63, 4'b0010);
    push_tick(127, 4'b1001);
    push_tick(191, 4'b0000);
    push_tick(207, 4'b0100);
    push_tick(223, 4'b0000);
    push_tick(239, 4'b0000);
    push_tick(303, 4'b0000);
    push_tick(467, 4'b0010);

    // Debounce latency: first sampled at edge 6, level/press at edge 11.
    wait_cyc(5);   btn_raw[1] = 1'b0; push_press(11, 4'b0010);
    wait_cyc(10);  check_eq("level_before_deb", btn_level, 4'b0000);
    wait_cyc(11);  check_eq("level_after_deb", btn_level, 4'b0010);
    wait_cyc(20);  btn_raw[1] = 1'b1;
    wait_cyc(25);  check_eq("level_hold_release", btn_level, 4'b0010);
    wait_cyc(26);  check_eq("level_released", btn_level, 4'b0000);
    // Three-sample glitch must be rejected.
    wait_cyc(30);  btn_raw[2] = 1'b0;
    wait_cyc(33);  btn_raw[2] = 1'b1;
    wait_cyc(40);  check_eq("glitch_level", btn_level, 4'b0000);

    wait_cyc(70);  btn_raw[0] = 1'b0; push_press(76, 4'b0001);
    wait_cyc(80);  btn_raw[3] = 1'b0; push_press(86, 4'b1000);
    wait_cyc(90);  btn_raw[0] = 1'b1;
    wait_cyc(95);  btn_raw[3] = 1'b1;

    wait_cyc(140); speed = 2'd2;
    // Press lands exactly in the tick cycle at 207.
    wait_cyc(201); btn_raw[2] = 1'b0; push_press(207, 4'b0100);
    wait_cyc(215); btn_raw[2] = 1'b1;
    wait_cyc(225); speed = 2'd0;

    // Pause at cnt=30 of the interval starting at 304, for 100 edges.
    wait_cyc(334); pause = 1'b1;
    wait_cyc(350); btn_raw[1] = 1'b0; push_press(356, 4'b0010);
    wait_cyc(365); btn_raw[1] = 1'b1;
    wait_cyc(434); pause = 1'b0;

    // Press pending mid-interval, then reset discards it.
    wait_cyc(480); btn_raw[0] = 1'b0; push_press(486, 4'b0001);
    wait_cyc(490); check_eq("level_pre_reset", btn_level, 4'b0001);
    check_eq("tick_btns_pre_reset", tick_btns, 4'b0010);
    wait_cyc(495); reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_tick", tick, 0);
    check_eq("mid_rst_clear", clear_pulse, 0);
    check_eq("mid_rst_slow", slow_clk, 0);
    check_eq("mid_rst_level", btn_level, 0);
    check_eq("mid_rst_press", btn_press, 0);
    check_eq("mid_rst_tick_btns", tick_btns, 0);
    reset   = 1'b0;
    btn_raw = 4'hF;
    push_tick(63, 4'b0000);

    wait_cyc(70);
    check_eq("tick_queue_empty", tick_q.size(), 0);
    check_eq("press_queue_empty", press_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
